// File: rtl/kws_argmax_detect.sv
// Keyword decision stage: tracks top-1/top-2 class scores over one frame and
// raises kw_detect when the same non-filler class passes thresholds CONFIRM frames in a row.
module kws_argmax_detect #(
  parameter int unsigned NUM_CLASSES    = 12,
  parameter int unsigned FILLER_CLASSES = 2,
  parameter int unsigned CONFIRM        = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        frame_clr,
  input  logic [31:0] score_th,
  input  logic [31:0] margin_th,
  output logic        out_valid,
  output logic [3:0]  out_class,
  output logic [31:0] out_score,
  output logic [31:0] out_margin,
  output logic        kw_detect,
  output logic        overrun
);

  localparam logic [3:0]  LAST_IDX   = 4'(NUM_CLASSES - 1);
  localparam logic [3:0]  CONFIRM_Q  = 4'(CONFIRM);
  localparam logic [4:0]  FILLER_Q   = 5'(FILLER_CLASSES);
  localparam logic [31:0] SCORE_MIN  = 32'h8000_0000;
  localparam logic [31:0] MARGIN_MAX = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DECIDE  = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic signed [31:0] top1;
  logic signed [31:0] top2;
  logic [3:0]         idx1;
  logic [3:0]         prev_idx;
  logic [3:0]         streak;

  logic [32:0]        diff_c;
  logic [31:0]        margin_c;
  logic               pass_c;
  logic [3:0]         streak_nxt_c;

  // Decision terms evaluated while in DECIDE; top1 >= top2 holds, so diff is non-negative
  always_comb begin
    diff_c       = {top1[31], top1} - {top2[31], top2};
    margin_c     = diff_c[32] ? 32'h0 : (diff_c[31] ? MARGIN_MAX : diff_c[31:0]);
    pass_c       = (top1 >= $signed(score_th)) && (margin_c >= margin_th) &&
                   ({1'b0, idx1} >= FILLER_Q);
    streak_nxt_c = 4'h0;
    if (pass_c) begin
      if (idx1 == prev_idx) begin
        streak_nxt_c = (streak < CONFIRM_Q) ? streak + 4'd1 : CONFIRM_Q;
      end else begin
        streak_nxt_c = 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      cnt        <= 4'h0;
      top1       <= SCORE_MIN;
      top2       <= SCORE_MIN;
      idx1       <= 4'h0;
      prev_idx   <= 4'hF;
      streak     <= 4'h0;
      out_valid  <= 1'b0;
      out_class  <= 4'h0;
      out_score  <= 32'h0;
      out_margin <= 32'h0;
      kw_detect  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      kw_detect <= 1'b0;
      overrun   <= 1'b0;
      if (frame_clr) begin
        // Abort wins over any coincident strobe, which is silently discarded
        state    <= COLLECT;
        cnt      <= 4'h0;
        streak   <= 4'h0;
        prev_idx <= 4'hF;
      end else begin
        if (in_valid && (state != COLLECT)) overrun <= 1'b1;
        case (state)
          COLLECT: begin
            if (in_valid) begin
              if (cnt == 4'h0) begin
                top1 <= $signed(in_data);
                idx1 <= 4'h0;
                top2 <= SCORE_MIN;
              end else if ($signed(in_data) > top1) begin
                top2 <= top1;
                top1 <= $signed(in_data);
                idx1 <= cnt;
              end else if ($signed(in_data) > top2) begin
                top2 <= $signed(in_data);
              end
              if (cnt == LAST_IDX) begin
                cnt   <= 4'h0;
                state <= DECIDE;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          DECIDE: begin
            streak     <= streak_nxt_c;
            prev_idx   <= idx1;
            out_valid  <= 1'b1;
            out_class  <= idx1;
            out_score  <= top1;
            out_margin <= margin_c;
            kw_detect  <= (streak_nxt_c == CONFIRM_Q);
            state      <= REPORT;
          end
          REPORT: begin
            // Refractory: a detection restarts the streak count
            if (kw_detect) streak <= 4'h0;
            state <= COLLECT;
          end
          default: state <= COLLECT;
        endcase
      end
    end
  end

endmodule

// File: doc/kws_argmax_detect.md
# kws_argmax_detect

Keyword-decision stage placed directly downstream of the `linear` classifier layer in the KWS pipeline. It consumes one frame of signed 1.7.24 class scores (one per `output_valid` pulse of `linear`) and tracks the top-1 and top-2 scores. At end of frame it emits the winning class, its score and the top-1/top-2 margin. It asserts a keyword detection only when the same non-filler class passes both thresholds for `CONFIRM` consecutive frames.

## Interface
- `NUM_CLASSES`, 12: scores per frame; 2..16.
- `FILLER_CLASSES`, 2: classes `0..FILLER_CLASSES-1` (silence/unknown) never trigger detection.
- `CONFIRM`, 3: consecutive passing frames required for detection; 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `in_data`  in  32  signed 1.7.24 class score (driven by `linear.output_data`).
- `in_valid`  in  1  score strobe (driven by `linear.output_valid`).
- `frame_clr`  in  1  synchronous abort of the current frame and the streak.
- `score_th`  in  32  signed 1.7.24 minimum top-1 score.
- `margin_th`  in  32  unsigned 1.7.24 minimum (top1 − top2).
- `out_valid`  out  1  one-cycle pulse: result fields are valid.
- `out_class`  out  4  index of the top-1 class.
- `out_score`  out  32  top-1 score.
- `out_margin`  out  32  saturated top1 − top2.
- `kw_detect`  out  1  one-cycle pulse coincident with `out_valid` on detection.
- `overrun`  out  1  one-cycle pulse when an `in_valid` is dropped.

## Operation
- States: COLLECT → DECIDE → REPORT → COLLECT. Reset enters COLLECT.
- Class index is arrival order within the frame, counted by `cnt` (4 bits). The `linear` address output is not used.
- COLLECT, `in_valid`=1, `cnt`=0: `top1`←`in_data`, `idx1`←0, `top2`←32'h80000000.
- COLLECT, `in_valid`=1, `cnt`>0, signed compare:
  - `in_data` > `top1`: `top2`←`top1`, `top1`←`in_data`, `idx1`←`cnt`.
  - Else if `in_data` > `top2`: `top2`←`in_data`.
  - Ties never replace, so the lower index wins.
- Every accepted sample increments `cnt`. The sample accepted with `cnt`=`NUM_CLASSES`−1 moves the FSM to DECIDE and clears `cnt`.
- DECIDE:
  - `margin` = `top1` − `top2`, computed in 33-bit signed; results above 32'h7FFFFFFF saturate to 32'h7FFFFFFF.
  - `pass` = (`top1` ≥ `score_th`, signed) && (`margin` ≥ `margin_th`, unsigned) && (`idx1` ≥ `FILLER_CLASSES`).
  - Streak update:
    - `pass` && `idx1`==`prev_idx`: `streak`←min(`streak`+1, `CONFIRM`).
    - `pass` with a different class: `streak`←1.
    - `!pass`: `streak`←0.
  - `prev_idx`←`idx1`.
- REPORT:
  - `out_valid`=1; `out_class`/`out_score`/`out_margin` are loaded.
  - `kw_detect`=1 iff `streak`==`CONFIRM`.
  - On detection, `streak`←0 (refractory: the next detection needs `CONFIRM` fresh frames).
- `in_valid` in DECIDE or REPORT: the sample is dropped and `overrun` pulses the next cycle.
- `frame_clr` (any state):
  - Next state COLLECT; `cnt`, `streak` ←0; `prev_idx`←4'hF.
  - No `out_valid` for the aborted frame.
  - `frame_clr` has priority over a coincident `in_valid`, which is discarded without `overrun`.
- Reset values:
  - All outputs 0.
  - `top1`, `top2` = 32'h80000000; `idx1`=0; `prev_idx`=4'hF; `streak`=0; `cnt`=0.

## Timing
- Accepts `in_valid` every cycle in COLLECT; back-to-back samples are legal.
- Last sample sampled at edge E0:
  - DECIDE during E0→E1.
  - REPORT during E1→E2; `out_valid`/`kw_detect` are registered high after E1 and low after E2.
- Latency from the last sample to `out_valid` is 2 cycles. A new frame can be accepted from the cycle after REPORT (3 cycles after E0).
- `out_class`, `out_score`, `out_margin` hold their values until the next REPORT.
- `overrun` is registered: it is high in the cycle after the dropped strobe.
- Asynchronous reset mid-frame discards the partial frame; outputs go to 0 immediately.

## Test plan
- Single frame; scores = class index × 1.0 (k<<24) for k=0..11; `score_th`=0; `margin_th`=0; `CONFIRM`=1 -> `out_valid` 2 cycles after the 12th sample; `out_class`=11, `out_score`=32'h0B000000, `out_margin`=32'h01000000, `kw_detect`=1.
- Three identical frames with class 5 = 3.0 and the rest −1.0; `margin_th`=1.0; `CONFIRM`=3 -> `kw_detect`=0, 0, 1. A fourth identical frame -> `kw_detect`=0 (refractory, `streak`=1).
- Ties and saturation: class 2 and class 7 both 32'h7FFFFFFF, others 32'h80000000 -> `out_class`=2, `out_margin`=0. A frame with one 32'h7FFFFFFF and the rest 32'h80000000 -> `out_margin`=32'h7FFFFFFF.
- Filler win: class 1 is the top at 5.0 with a large margin -> `out_valid`=1, `out_class`=1, `kw_detect`=0, `streak` cleared.
- `frame_clr` after 6 samples, then a full frame -> exactly one `out_valid`, computed from the new frame only. `in_valid` pulsed during DECIDE -> `overrun` pulse; the next frame still decodes correctly.
- `rst_n` low mid-frame (after 4 samples), then released -> all outputs 0; the following 12-sample frame gives the correct result with `streak` starting from 0.
